// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// spi_reg_master : mode-0 SPI initiator for {rw, addr, data} register frames.
// Optional feature macro SPI_REG_MASTER_ABORT_EN adds cmd_abort / rsp_aborted.
// Revision: 1.0 - initial release
// ============================================================================
module spi_reg_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4   // clk cycles per sck half-period, must be >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SPI_REG_MASTER_ABORT_EN
  input  logic                  cmd_abort,
  output logic                  rsp_aborted,
`endif
  output logic                  busy,
  output logic                  sck_o,
  output logic                  sdo_o,
  input  logic                  sdi_i,
  output logic                  cs_no
);

  localparam int FRAME_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int TOGGLES     = 2 * FRAME_WIDTH;
  localparam int DIV_W       = $clog2(CLK_DIV);
  localparam int TGL_W       = $clog2(TOGGLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  // GAP is one cycle shorter because the IDLE cycle also keeps cs_no high.
  localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'(CLK_DIV - 2);
  localparam logic [TGL_W-1:0] TGL_LAST   = TGL_W'(TOGGLES);
  localparam logic [TGL_W-1:0] TGL_PENULT = TGL_W'(TOGGLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                 state, state_nx;
  logic [DIV_W-1:0]       div_cnt, div_nx;
  logic [TGL_W-1:0]       tgl_cnt, tgl_nx;
  logic [FRAME_WIDTH-1:0] tx_shift, tx_nx;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_nx, rdata_nx;
  logic                   cs_nx, sck_nx, sdo_nx, rvalid_nx, ready_nx;
  logic                   div_done;
`ifdef SPI_REG_MASTER_ABORT_EN
  logic                   aborted_nx;
`endif

  assign div_done = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      tgl_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      cs_no       <= 1'b1;
      sck_o       <= 1'b0;
      sdo_o       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef SPI_REG_MASTER_ABORT_EN
      rsp_aborted <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      div_cnt     <= div_nx;
      tgl_cnt     <= tgl_nx;
      tx_shift    <= tx_nx;
      rx_shift    <= rx_nx;
      cmd_ready   <= ready_nx;
      busy        <= ~ready_nx;
      cs_no       <= cs_nx;
      sck_o       <= sck_nx;
      sdo_o       <= sdo_nx;
      rsp_valid   <= rvalid_nx;
      rsp_rdata   <= rdata_nx;
`ifdef SPI_REG_MASTER_ABORT_EN
      rsp_aborted <= aborted_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    div_nx     = div_cnt;
    tgl_nx     = tgl_cnt;
    tx_nx      = tx_shift;
    rx_nx      = rx_shift;
    ready_nx   = cmd_ready;
    cs_nx      = cs_no;
    sck_nx     = sck_o;
    sdo_nx     = sdo_o;
    rvalid_nx  = 1'b0;
    rdata_nx   = rsp_rdata;
`ifdef SPI_REG_MASTER_ABORT_EN
    aborted_nx = rsp_aborted;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tx_nx    = {cmd_rw, cmd_addr, (cmd_rw ? {DATA_WIDTH{1'b0}} : cmd_wdata)};
          rx_nx    = '0;
          div_nx   = '0;
          tgl_nx   = '0;
          cs_nx    = 1'b0;
          sdo_nx   = cmd_rw;
          ready_nx = 1'b0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          // The SETUP terminal count is itself the first rising sck edge.
          div_nx   = '0;
          tgl_nx   = TGL_W'(1);
          sck_nx   = 1'b1;
          rx_nx    = {rx_shift[DATA_WIDTH-2:0], sdi_i};
          state_nx = SHIFT;
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_done) begin
          div_nx = '0;
          if (tgl_cnt == TGL_LAST) begin
            state_nx = HOLD;
          end else begin
            tgl_nx = tgl_cnt + TGL_W'(1);
            sck_nx = ~sck_o;
            if (!sck_o) begin
              rx_nx = {rx_shift[DATA_WIDTH-2:0], sdi_i};
            end else if (tgl_cnt != TGL_PENULT) begin
              tx_nx  = tx_shift << 1;
              sdo_nx = tx_shift[FRAME_WIDTH-2];
            end
          end
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_done) begin
          div_nx     = '0;
          cs_nx      = 1'b1;
          sdo_nx     = 1'b0;
          rvalid_nx  = 1'b1;
          rdata_nx   = rx_shift;
`ifdef SPI_REG_MASTER_ABORT_EN
          aborted_nx = 1'b0;
`endif
          state_nx   = GAP;
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_cnt == GAP_LAST) begin
          div_nx   = '0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        cs_nx    = 1'b1;
        sck_nx   = 1'b0;
        sdo_nx   = 1'b0;
      end
    endcase

`ifdef SPI_REG_MASTER_ABORT_EN
    if (cmd_abort && (state == SETUP || state == SHIFT)) begin
      state_nx   = GAP;
      div_nx     = '0;
      tgl_nx     = '0;
      tx_nx      = tx_shift;
      rx_nx      = rx_shift;
      sck_nx     = 1'b0;
      cs_nx      = 1'b1;
      sdo_nx     = 1'b0;
      rvalid_nx  = 1'b1;
      aborted_nx = 1'b1;
    end
`endif
  end

endmodule
`default_nettype wire
